// File: rtl/serializer_param.sv
// Parametrised parallel-to-serial converter: captures a DATA_W-bit word with a
// programmable bit count and shifts it out one bit per clock, MSB- or LSB-first.
module serializer_param #(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_LEN   = 3,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so that a full-width length does not wrap to zero.
  localparam int LEN_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt, len;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic              bit_nxt, val_nxt, busy_nxt;
  logic              len_ok, accept;

  function automatic logic front(input logic [DATA_W-1:0] d);
    return LSB_FIRST ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] rest(input logic [DATA_W-1:0] d);
    return LSB_FIRST ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    len = (data_mod_i == '0) ? LEN_W'(DATA_W) : LEN_W'(data_mod_i);
  end

  assign len_ok = (len >= LEN_W'(MIN_LEN));
  // busy_o is low in IDLE and during the final bit, which is what lets a new
  // word load on the same edge the previous one finishes.
  assign accept = data_val_i && !busy_o && len_ok;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    bit_nxt   = 1'b0;
    val_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    if (accept) begin
      state_nxt = SHIFT;
      cnt_nxt   = len;
      bit_nxt   = front(data_i);
      sreg_nxt  = rest(data_i);
      val_nxt   = 1'b1;
      busy_nxt  = (len > LEN_W'(1));
    end else begin
      case (state)
        SHIFT: begin
          if (cnt > LEN_W'(1)) begin
            cnt_nxt  = cnt - LEN_W'(1);
            bit_nxt  = front(sreg);
            sreg_nxt = rest(sreg);
            val_nxt  = 1'b1;
            busy_nxt = (cnt_nxt > LEN_W'(1));
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sreg_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      sreg           <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      sreg           <= sreg_nxt;
      ser_data_o     <= bit_nxt;
      ser_data_val_o <= val_nxt;
      busy_o         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serializer_param.sv
// Scoreboard bench for serializer_param: three instances (16-bit MSB-first,
// 8-bit LSB-first, 32-bit MSB-first) driven from one stimulus process.
module tb_serializer_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] d0; logic [3:0] m0; logic v0, sd0, sv0, bz0;
  logic [7:0]  d1; logic [2:0] m1; logic v1, sd1, sv1, bz1;
  logic [31:0] d2; logic [4:0] m2; logic v2, sd2, sv2, bz2;

  serializer_param #(.DATA_W(16)) u0 (
    .clk_i(clk), .srst_i(rst), .data_i(d0), .data_mod_i(m0), .data_val_i(v0),
    .ser_data_o(sd0), .ser_data_val_o(sv0), .busy_o(bz0));
  serializer_param #(.DATA_W(8), .LSB_FIRST(1'b1)) u1 (
    .clk_i(clk), .srst_i(rst), .data_i(d1), .data_mod_i(m1), .data_val_i(v1),
    .ser_data_o(sd1), .ser_data_val_o(sv1), .busy_o(bz1));
  serializer_param #(.DATA_W(32)) u2 (
    .clk_i(clk), .srst_i(rst), .data_i(d2), .data_mod_i(m2), .data_val_i(v2),
    .ser_data_o(sd2), .ser_data_val_o(sv2), .busy_o(bz2));

  typedef struct {bit b; int cyc;} exp_t;
  exp_t q0[$], q1[$], q2[$];

  localparam int MINL = 3;
  int W[3]   = '{16, 8, 32};
  int MW[3]  = '{4, 3, 5};
  bit LSB[3] = '{1'b0, 1'b1, 1'b0};

  // Reference model: a word accepted at edge k owns the line for edges k..k+L-1.
  int free_edge[3] = '{0, 0, 0};
  int last_k[3]    = '{0, 0, 0};
  int last_l[3]    = '{0, 0, 0};
  bit last_v[3]    = '{1'b0, 1'b0, 1'b0};

  int edge_n = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push(input int idx, input exp_t x);
    case (idx)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic idle_all();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic drive(input int idx, input logic [31:0] d, input int mod, output bit acc);
    int k, len;
    exp_t x;
    case (idx)
      0: begin d0 = d[15:0]; m0 = 4'(mod); v0 = 1'b1; end
      1: begin d1 = d[7:0];  m1 = 3'(mod); v1 = 1'b1; end
      default: begin d2 = d; m2 = 5'(mod); v2 = 1'b1; end
    endcase
    k   = edge_n + 1;
    len = (mod == 0) ? W[idx] : mod;
    acc = !rst && len >= MINL && k >= free_edge[idx];
    if (acc) begin
      for (int i = 0; i < len; i++) begin
        x.b   = LSB[idx] ? d[i] : d[W[idx]-1-i];
        x.cyc = k + i;
        push(idx, x);
      end
      last_k[idx] = k; last_l[idx] = len; last_v[idx] = 1'b1;
      free_edge[idx] = k + len;
    end
  endtask

  // Called at a negedge: reset is sampled on the following edge.
  task automatic do_rst();
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      last_v[i] = 1'b0;
      free_edge[i] = edge_n + 2;
    end
  endtask

  task automatic mon_one(input int idx, input logic sv, input logic sd, input logic bz);
    exp_t f;
    bit has = 1'b0;
    bit eb;
    int e = edge_n;
    case (idx)
      0: if (q0.size() > 0) begin f = q0[0]; has = 1'b1; end
      1: if (q1.size() > 0) begin f = q1[0]; has = 1'b1; end
      default: if (q2.size() > 0) begin f = q2[0]; has = 1'b1; end
    endcase
    if (has && f.cyc < e) begin
      total++; bad++;
      $display("FAIL stale inst%0d cyc=%0d expected bit for cyc %0d never appeared", idx, e, f.cyc);
      case (idx)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
      has = 1'b0;
    end
    total++;
    if (has && f.cyc == e) begin
      if (sv !== 1'b1 || sd !== f.b) begin
        bad++;
        $display("FAIL bit inst%0d cyc=%0d got val=%b bit=%b want val=1 bit=%b", idx, e, sv, sd, f.b);
      end
      case (idx)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end else if (sv !== 1'b0 || sd !== 1'b0) begin
      bad++;
      $display("FAIL idle inst%0d cyc=%0d got val=%b bit=%b want val=0 bit=0", idx, e, sv, sd);
    end
    eb = last_v[idx] && e >= last_k[idx] && e <= last_k[idx] + last_l[idx] - 2;
    total++;
    if (bz !== eb) begin
      bad++;
      $display("FAIL busy inst%0d cyc=%0d got %b want %b", idx, e, bz, eb);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      #1;
      mon_one(0, sv0, sd0, bz0);
      mon_one(1, sv1, sd1, bz1);
      mon_one(2, sv2, sd2, bz2);
      @(posedge clk);
    end
  end

  initial begin
    bit acc;
    int phase;
    rst = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; m0 = '0; m1 = '0; m2 = '0;
    idle_all();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Full 16-bit word, MSB first.
    @(negedge clk); idle_all(); drive(0, 32'hA5C3, 0, acc);
    repeat (20) begin @(negedge clk); idle_all(); end

    // Short word, then too-short requests that must be dropped.
    @(negedge clk); idle_all(); drive(0, 32'hF800, 5, acc);
    repeat (8) begin @(negedge clk); idle_all(); end
    @(negedge clk); idle_all(); drive(0, 32'hFFFF, 2, acc);
    @(negedge clk); idle_all(); drive(0, 32'hFFFF, 1, acc);
    repeat (4) begin @(negedge clk); idle_all(); end

    // LSB-first 8-bit and full-width 32-bit words.
    @(negedge clk); idle_all(); drive(1, 32'h01, 0, acc); drive(2, $urandom, 0, acc);
    repeat (36) begin @(negedge clk); idle_all(); end

    // Streaming: strobe held high, data switches once the first word is taken.
    phase = 0;
    for (int c = 0; c < 40 && phase < 2; c++) begin
      @(negedge clk); idle_all();
      drive(0, (phase == 0) ? 32'hFFFF : 32'h0000, 0, acc);
      if (acc) phase++;
    end
    total++;
    if (phase != 2) begin
      bad++;
      $display("FAIL stream_accepts got %0d want 2", phase);
    end
    @(negedge clk); idle_all();
    repeat (20) begin @(negedge clk); idle_all(); end

    // Reset during bit 7, with a strobe in the reset cycle, then a fresh word.
    @(negedge clk); idle_all(); drive(0, $urandom, 0, acc);
    repeat (6) begin @(negedge clk); idle_all(); end
    @(negedge clk); idle_all(); do_rst(); drive(0, 32'hFFFF, 0, acc);
    @(negedge clk); idle_all(); rst = 1'b0;
    @(negedge clk); idle_all(); drive(0, $urandom, 0, acc);
    repeat (20) begin @(negedge clk); idle_all(); end

    // Random traffic on all instances.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); idle_all();
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 2) == 0)
          drive(i, $urandom, int'($urandom_range(0, (1 << MW[i]) - 1)), acc);
    end
    repeat (40) begin @(negedge clk); idle_all(); end

    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending bits want 0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
